// File: rtl/pattern_gen_if.sv
// Control/status bundle for the serial pattern generator.
// The master side issues sends; the slave side is the generator itself.
interface pattern_gen_if #(
   parameter int WIDTH = 16,
   parameter int LW    = 5
);
   logic             start;
   logic             abort;
   logic [WIDTH-1:0] pattern;
   logic [LW-1:0]    len;
   logic [3:0]       rpt;
   logic [3:0]       gap;
   logic             out;
   logic             out_valid;
   logic             busy;
   logic             done;

   modport master (
      output start, abort, pattern, len, rpt, gap,
      input  out, out_valid, busy, done
   );

   modport slave (
      input  start, abort, pattern, len, rpt, gap,
      output out, out_valid, busy, done
   );
endinterface

// File: rtl/pattern_gen.sv
// Serial pattern generator: sends a latched pattern LSB first,
// repeated rpt+1 times with optional idle gaps between repetitions.
module pattern_gen #(
   parameter int WIDTH = 16,
   parameter int LW    = 5
) (
   input  logic         clk,
   input  logic         reset,
   pattern_gen_if.slave bus
);
   typedef enum logic [1:0] {IDLE, SHIFT, GAP, DONE} state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] pat_q, pat_d;
   logic [WIDTH-1:0] sh_q, sh_d;
   logic [LW-1:0]    len_q, len_d;
   logic [LW-1:0]    idx_q, idx_d;
   logic [3:0]       rpt_q, rpt_d;
   logic [3:0]       gap_q, gap_d;
   logic [3:0]       gcnt_q, gcnt_d;
   logic             out_q, out_d;
   logic             valid_q, valid_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [LW-1:0]    eff_len;

   assign bus.out       = out_q;
   assign bus.out_valid = valid_q;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;

   always_comb begin
      eff_len = bus.len;
      if (bus.len == '0 || bus.len > LW'(WIDTH))
         eff_len = LW'(WIDTH);
   end

   // sh_q holds the pattern shifted right by idx_q, so sh_q[0] is the bit on the wire
   always_comb begin
      state_d = state_q;
      pat_d   = pat_q;
      sh_d    = sh_q;
      len_d   = len_q;
      idx_d   = idx_q;
      rpt_d   = rpt_q;
      gap_d   = gap_q;
      gcnt_d  = gcnt_q;
      unique case (state_q)
         IDLE: begin
            if (bus.start && !bus.abort) begin
               state_d = SHIFT;
               pat_d   = bus.pattern;
               sh_d    = bus.pattern;
               len_d   = eff_len;
               rpt_d   = bus.rpt;
               gap_d   = bus.gap;
               idx_d   = '0;
            end
         end
         SHIFT: begin
            if (bus.abort) begin
               state_d = IDLE;
            end else if (idx_q == len_q - 1'b1) begin
               idx_d = '0;
               sh_d  = pat_q;
               if (rpt_q == 4'd0) begin
                  state_d = DONE;
               end else begin
                  rpt_d = rpt_q - 4'd1;
                  if (gap_q != 4'd0) begin
                     state_d = GAP;
                     gcnt_d  = gap_q;
                  end
               end
            end else begin
               idx_d = idx_q + 1'b1;
               sh_d  = sh_q >> 1;
            end
         end
         GAP: begin
            if (bus.abort)
               state_d = IDLE;
            else if (gcnt_q == 4'd1)
               state_d = SHIFT;
            else
               gcnt_d = gcnt_q - 4'd1;
         end
         DONE: state_d = IDLE;
      endcase
      out_d   = (state_d == SHIFT) ? sh_d[0] : 1'b1;
      valid_d = (state_d == SHIFT);
      busy_d  = (state_d == SHIFT) || (state_d == GAP);
      done_d  = (state_d == DONE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         pat_q   <= '0;
         sh_q    <= '0;
         len_q   <= '0;
         idx_q   <= '0;
         rpt_q   <= '0;
         gap_q   <= '0;
         gcnt_q  <= '0;
         out_q   <= 1'b1;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pat_q   <= pat_d;
         sh_q    <= sh_d;
         len_q   <= len_d;
         idx_q   <= idx_d;
         rpt_q   <= rpt_d;
         gap_q   <= gap_d;
         gcnt_q  <= gcnt_d;
         out_q   <= out_d;
         valid_q <= valid_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end
endmodule

// File: tb/tb_pattern_gen.sv
// Bench for pattern_gen: directed scenarios plus randomized sends
// compared cycle by cycle against an expected output sequence.
module tb_pattern_gen;
   localparam int W = 16;
   localparam int L = 5;
   localparam logic [3:0] IDLE_OBS = 4'b1000;

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   failures = 0;

   pattern_gen_if #(.WIDTH(W), .LW(L)) bus ();

   pattern_gen #(.WIDTH(W), .LW(L)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // {out, out_valid, busy, done}
   function automatic logic [3:0] obs();
      return {bus.out, bus.out_valid, bus.busy, bus.done};
   endfunction

   task automatic scramble();
      bus.pattern = 16'($urandom);
      bus.len     = 5'($urandom);
      bus.rpt     = 4'($urandom);
      bus.gap     = 4'($urandom);
   endtask

   // kill_at: sequence index at which abort (or reset) is raised, -1 for none
   task automatic run_txn(input logic [15:0] p, input logic [4:0] ln,
                          input logic [3:0] rp, input logic [3:0] gp,
                          input int kill_at, input bit kill_rst,
                          input bit noise);
      logic [3:0] exp_q[$];
      int el;
      el = (ln == 5'd0 || ln > 5'd16) ? 16 : int'(ln);
      for (int r = 0; r <= int'(rp); r++) begin
         for (int i = 0; i < el; i++) exp_q.push_back({p[i], 3'b110});
         if (r < int'(rp))
            for (int g = 0; g < int'(gp); g++) exp_q.push_back(4'b1010);
      end
      exp_q.push_back(4'b1001);
      exp_q.push_back(IDLE_OBS);
      @(negedge clk);
      bus.pattern = p;
      bus.len     = ln;
      bus.rpt     = rp;
      bus.gap     = gp;
      bus.start   = 1'b1;
      bus.abort   = 1'b0;
      for (int k = 0; k < exp_q.size(); k++) begin
         @(negedge clk);
         check($sformatf("seq[%0d]", k), {28'd0, obs()}, {28'd0, exp_q[k]});
         bus.start = (noise && k < exp_q.size() - 1) ? 1'($urandom) : 1'b0;
         bus.abort = 1'b0;
         if (noise) scramble();
         if (k == kill_at) begin
            if (kill_rst) reset = 1'b1;
            else bus.abort = 1'b1;
            @(negedge clk);
            check("kill", {28'd0, obs()}, {28'd0, IDLE_OBS});
            reset     = 1'b0;
            bus.abort = 1'b0;
            bus.start = 1'b0;
            @(negedge clk);
            check("post_kill", {28'd0, obs()}, {28'd0, IDLE_OBS});
            break;
         end
      end
   endtask

   initial begin
      logic [15:0] p2;
      logic [3:0]  e;
      reset       = 1'b1;
      bus.start   = 1'b0;
      bus.abort   = 1'b0;
      bus.pattern = '0;
      bus.len     = '0;
      bus.rpt     = '0;
      bus.gap     = '0;
      repeat (2) @(negedge clk);
      check("reset", {28'd0, obs()}, {28'd0, IDLE_OBS});
      reset = 1'b0;

      run_txn(16'h0006, 5'd3, 4'd0, 4'd0, -1, 1'b0, 1'b0);
      run_txn(16'h0005, 5'd3, 4'd1, 4'd2, -1, 1'b0, 1'b0);
      run_txn(16'hA5C3, 5'd0, 4'd0, 4'd0, -1, 1'b0, 1'b0);
      run_txn(16'h1234, 5'd16, 4'd0, 4'd0, 5, 1'b0, 1'b1);
      run_txn(16'h0005, 5'd3, 4'd1, 4'd2, 3, 1'b1, 1'b0);
      run_txn(16'h0006, 5'd3, 4'd0, 4'd0, -1, 1'b0, 1'b0);
      run_txn(16'h0001, 5'd1, 4'd15, 4'd0, -1, 1'b0, 1'b1);
      run_txn(16'hBEEF, 5'd20, 4'd2, 4'd1, -1, 1'b0, 1'b1);

      // start held high: sends repeat every 4 cycles (2 bits, DONE, IDLE)
      p2 = 16'h0002;
      @(negedge clk);
      bus.pattern = p2;
      bus.len     = 5'd2;
      bus.rpt     = 4'd0;
      bus.gap     = 4'd0;
      bus.start   = 1'b1;
      bus.abort   = 1'b0;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         if (c % 4 < 2) e = {p2[c % 4], 3'b110};
         else if (c % 4 == 2) e = 4'b1001;
         else e = IDLE_OBS;
         check($sformatf("hold[%0d]", c), {28'd0, obs()}, {28'd0, e});
      end
      bus.start = 1'b0;
      @(negedge clk);
      check("hold_end", {28'd0, obs()}, {28'd0, IDLE_OBS});

      // start together with abort in IDLE is suppressed
      bus.start = 1'b1;
      bus.abort = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      bus.abort = 1'b0;
      for (int c = 0; c < 3; c++) begin
         check($sformatf("sa[%0d]", c), {28'd0, obs()}, {28'd0, IDLE_OBS});
         @(negedge clk);
      end

      for (int n = 0; n < 40; n++) begin
         logic [15:0] rp_pat;
         logic [4:0]  rl;
         logic [3:0]  rr, rg;
         int          el, ka;
         rp_pat = 16'($urandom);
         rl     = 5'($urandom);
         rr     = 4'($urandom_range(0, 4));
         rg     = 4'($urandom_range(0, 3));
         el     = (rl == 5'd0 || rl > 5'd16) ? 16 : int'(rl);
         ka     = ($urandom_range(0, 3) == 0) ? $urandom_range(0, el - 1) : -1;
         run_txn(rp_pat, rl, rr, rg, ka, 1'($urandom), 1'b1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/pattern_gen.md
PATTERN_GEN -- requirements
Module: pattern_gen

Interface
REQ-001 Parameter WIDTH, default 16, sets the pattern register width in bits; legal range 2..32.
REQ-002 Parameter LW, default 5, sets the len port width; it SHALL equal clog2(WIDTH)+1.
REQ-003 clk  input  1  single system clock; all state SHALL change on its rising edge only.
REQ-004 reset  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-005 start  input  1  request a transmission; sampled only in IDLE.
REQ-006 abort  input  1  terminate an in-progress transmission.
REQ-007 pattern  input  WIDTH  bit pattern to send, transmitted LSB first.
REQ-008 len  input  LW  number of pattern bits per repetition; 0 or values above WIDTH SHALL be treated as WIDTH.
REQ-009 rpt  input  4  number of additional repetitions; 0 means send once, so the pattern is sent rpt+1 times.
REQ-010 gap  input  4  idle cycles inserted between repetitions.
REQ-011 out  output  1  registered serial data; idle level is 1.
REQ-012 out_valid  output  1  high exactly when out carries a pattern bit.
REQ-013 busy  output  1  high from the first bit through the last bit or the last gap cycle.
REQ-014 done  output  1  one-cycle pulse on normal completion.

Function
REQ-015 The FSM SHALL have exactly four states: IDLE, SHIFT, GAP and DONE.
REQ-016 IDLE: out=1, out_valid=0, busy=0, done=0.
REQ-017 IDLE to SHIFT: on an edge where start=1 and abort=0, the block SHALL latch pattern, effective len, rpt and gap.
REQ-018 Latched values SHALL be the only ones used; input changes while busy SHALL be ignored.
REQ-019 Latency: if start is sampled at edge T, bit 0 SHALL appear on out with out_valid=1 in the cycle after T.
REQ-020 Bit i of each repetition SHALL follow bit 0 by i cycles, with no stalls.
REQ-021 SHIFT: out=pattern[bit_idx], out_valid=1, busy=1; bit_idx SHALL run 0 to len-1 and reset to 0 for each repetition.
REQ-022 After bit len-1 of a non-final repetition with gap>0, the FSM SHALL enter GAP.
REQ-023 GAP SHALL last exactly gap cycles with out=1, out_valid=0, busy=1, then return to SHIFT at bit 0.
REQ-024 After bit len-1 of a non-final repetition with gap=0, the next cycle SHALL carry bit 0 of the next repetition back-to-back.
REQ-025 After bit len-1 of the final repetition, the FSM SHALL enter DONE for exactly one cycle: done=1, busy=0, out=1, out_valid=0; it SHALL then go to IDLE.
REQ-026 start asserted during SHIFT, GAP or DONE SHALL be ignored and not queued.
REQ-027 A new start is accepted only once the FSM is in IDLE, so there is at least one idle cycle after done.
REQ-028 An edge with abort=1 in SHIFT or GAP SHALL force IDLE on the next cycle with no done pulse.
REQ-029 abort in IDLE or DONE SHALL have no effect, except that abort=1 together with start=1 in IDLE SHALL suppress the start.
REQ-030 The repetition counter SHALL count down from the latched rpt; a 4-bit rpt=15 SHALL yield 16 repetitions with no wrap error.
REQ-031 len=1 SHALL produce one-cycle repetitions.

Reset
REQ-032 An edge with reset=1 SHALL force IDLE and set out=1, out_valid=0, busy=0, done=0, and clear all counters and latched registers.
REQ-033 reset SHALL take priority over start and abort.
REQ-034 Reset mid-transmission SHALL abandon the transmission without a done pulse, and the outputs of REQ-032 SHALL appear the cycle after the reset edge.

Verification
REQ-035 The bench SHALL cover these directed scenarios:
- pattern=16'h0006, len=3, rpt=0, gap=0, start at edge T -> out 0,1,1 in cycles T+1..T+3 with out_valid=1, done=1 in cycle T+4, busy low in cycle T+4.
- pattern=16'h0005, len=3, rpt=1, gap=2 -> out_valid sequence 1,1,1,0,0,1,1,1, out bits 1,0,1,-,-,1,0,1, a single done pulse after that, and out=1 during the gap.
- pattern=16'hA5C3, len=0, rpt=0 -> 16 bits, LSB first: 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1.
- abort asserted during bit 5 of a 16-bit send -> next cycle out=1, out_valid=0, busy=0, and done never pulses.
- reset asserted during GAP -> next cycle all outputs at reset values; a start afterwards behaves as in the first scenario.
- start=1 held continuously with len=2, rpt=0 -> sends separated by exactly two non-valid cycles (the DONE cycle and the IDLE cycle); start and abort both high in IDLE -> no transmission.
